// File: rtl/acc_core.sv
// acc_core: 8-bit-style accumulator CPU execution core (cc=01 ALU group plus index/carry ops).
// Optional BCD arithmetic (SED/CLD, decimal ADC/SBC) is enabled by defining DECIMAL_MODE_EN.
module acc_core #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  output logic [ADDR_W-1:0] addr,
  output logic              write,
  output logic              sync,
  output logic              illegal,
  output logic [7:0]        status
);

  localparam int MSB = DATA_W - 1;

  typedef enum logic [2:0] {ST_FETCH, ST_OPER, ST_ZPX, ST_ABSH, ST_FIX, ST_EXEC} state_t;
  typedef enum logic [2:0] {M_IMP, M_IMM, M_ZP, M_ZPX, M_ABS, M_ABX, M_ABY} mode_t;
  // The first eight codes follow the aaa field of a group-01 opcode.
  typedef enum logic [4:0] {
    OP_ORA, OP_AND, OP_EOR, OP_ADC, OP_STA, OP_LDA, OP_CMP, OP_SBC,
    OP_LDX, OP_LDY, OP_INX, OP_INY, OP_CLC, OP_SEC, OP_SED, OP_CLD, OP_NOP
  } op_t;
  typedef struct packed {
    op_t   op;
    mode_t mode;
    logic  legal;
  } dec_t;

  state_t              state_q, state_n;
  logic [ADDR_W-1:0]   pc_q;
  logic [DATA_W-1:0]   a_q, x_q, y_q, ir_q, adl_q, adh_q;
  logic                carry_q, n_q, v_q, z_q, c_q, d_flag;

  dec_t                dec;
  logic [7:0]          opc;
  logic [2*DATA_W-1:0] abs_full;
  logic [DATA_W-1:0]   idx, m_eff;
  logic [DATA_W:0]     bin_sum, cmp_sum, idx_sum;
  logic                add_v, advance;

  logic                pc_inc, ir_load, adl_load, adh_load, carry_load, exec_en;
  logic [DATA_W-1:0]   adl_n, adh_n;
  logic                carry_n;

  logic [DATA_W-1:0]   a_n, x_n, y_n, nz_val;
  logic                n_n, v_n, z_n, c_n, nz_upd;

  assign opc      = ir_q[7:0];
  assign abs_full = {adh_q, adl_q};
  assign idx      = (dec.mode == M_ABY) ? y_q : x_q;
  assign idx_sum  = {1'b0, adl_q} + {1'b0, idx};

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    dec = '{op: OP_NOP, mode: M_IMP, legal: 1'b0};
    if ((ir_q >> 8) == '0) begin
      if (opc[1:0] == 2'b01) begin
        dec.op    = op_t'({2'b00, opc[7:5]});
        dec.legal = 1'b1;
        case (opc[4:2])
          3'b001:  dec.mode = M_ZP;
          3'b010:  begin dec.mode = M_IMM; dec.legal = (opc[7:5] != 3'b100); end
          3'b011:  dec.mode = M_ABS;
          3'b101:  dec.mode = M_ZPX;
          3'b110:  dec.mode = M_ABY;
          3'b111:  dec.mode = M_ABX;
          default: dec.legal = 1'b0;
        endcase
      end else begin
        dec.legal = 1'b1;
        case (opc)
          8'hA2:   begin dec.op = OP_LDX; dec.mode = M_IMM; end
          8'hA0:   begin dec.op = OP_LDY; dec.mode = M_IMM; end
          8'hE8:   dec.op = OP_INX;
          8'hC8:   dec.op = OP_INY;
          8'h18:   dec.op = OP_CLC;
          8'h38:   dec.op = OP_SEC;
          8'hEA:   dec.op = OP_NOP;
`ifdef DECIMAL_MODE_EN
          8'hF8:   dec.op = OP_SED;
          8'hD8:   dec.op = OP_CLD;
`endif
          default: dec.legal = 1'b0;
        endcase
      end
    end
    if (!dec.legal) dec = '{op: OP_NOP, mode: M_IMP, legal: 1'b0};
  end

  // SBC reuses the adder with the operand inverted; CMP always subtracts with carry-in 1.
  assign m_eff   = (dec.op == OP_SBC) ? ~d_in : d_in;
  assign bin_sum = {1'b0, a_q} + {1'b0, m_eff} + {{DATA_W{1'b0}}, c_q};
  assign cmp_sum = {1'b0, a_q} + {1'b0, ~d_in} + {{DATA_W{1'b0}}, 1'b1};
  assign add_v   = (a_q[MSB] == m_eff[MSB]) && (bin_sum[MSB] != a_q[MSB]);

`ifdef DECIMAL_MODE_EN
  logic              d_q, d_n, dec_c;
  logic [4:0]        nib;
  logic [DATA_W-1:0] dec_res;

  // Nibble-serial BCD: ADC corrects sums above 9, SBC corrects nibbles that borrowed.
  always_comb begin
    dec_c   = c_q;
    dec_res = '0;
    nib     = '0;
    for (int i = 0; i < DATA_W / 4; i++) begin
      nib = {1'b0, a_q[4*i +: 4]} + {1'b0, m_eff[4*i +: 4]} + {4'b0, dec_c};
      if (dec.op == OP_SBC) begin
        dec_c = nib[4];
        if (!dec_c) nib = nib - 5'd6;
      end else if (nib > 5'd9) begin
        nib   = nib + 5'd6;
        dec_c = 1'b1;
      end else begin
        dec_c = 1'b0;
      end
      dec_res[4*i +: 4] = nib[3:0];
    end
  end
  assign d_flag = d_q;
`else
  assign d_flag = 1'b0;
`endif

  always_comb begin
    a_n = a_q; x_n = x_q; y_n = y_q;
    n_n = n_q; v_n = v_q; z_n = z_q; c_n = c_q;
    nz_val = '0;
    nz_upd = 1'b0;
`ifdef DECIMAL_MODE_EN
    d_n = d_q;
`endif
    case (dec.op)
      OP_ORA: begin a_n = a_q | d_in; nz_val = a_n; nz_upd = 1'b1; end
      OP_AND: begin a_n = a_q & d_in; nz_val = a_n; nz_upd = 1'b1; end
      OP_EOR: begin a_n = a_q ^ d_in; nz_val = a_n; nz_upd = 1'b1; end
      OP_LDA: begin a_n = d_in;       nz_val = a_n; nz_upd = 1'b1; end
      OP_ADC, OP_SBC: begin
        a_n = bin_sum[MSB:0];
        c_n = bin_sum[DATA_W];
`ifdef DECIMAL_MODE_EN
        if (d_q) begin
          a_n = dec_res;
          c_n = dec_c;
        end
`endif
        v_n    = add_v;
        nz_val = bin_sum[MSB:0];
        nz_upd = 1'b1;
      end
      OP_CMP: begin c_n = cmp_sum[DATA_W]; nz_val = cmp_sum[MSB:0]; nz_upd = 1'b1; end
      OP_LDX: begin x_n = d_in;      nz_val = x_n; nz_upd = 1'b1; end
      OP_LDY: begin y_n = d_in;      nz_val = y_n; nz_upd = 1'b1; end
      OP_INX: begin x_n = x_q + 1'b1; nz_val = x_n; nz_upd = 1'b1; end
      OP_INY: begin y_n = y_q + 1'b1; nz_val = y_n; nz_upd = 1'b1; end
      OP_CLC: c_n = 1'b0;
      OP_SEC: c_n = 1'b1;
`ifdef DECIMAL_MODE_EN
      OP_SED: d_n = 1'b1;
      OP_CLD: d_n = 1'b0;
`endif
      default: ;
    endcase
    if (nz_upd) begin
      n_n = nz_val[MSB];
      z_n = (nz_val == '0);
    end
  end

  // Sequencer: picks the bus address and which registers load this cycle.
  always_comb begin
    state_n    = state_q;
    addr       = abs_full[ADDR_W-1:0];
    write      = 1'b0;
    sync       = 1'b0;
    illegal    = 1'b0;
    pc_inc     = 1'b0;
    ir_load    = 1'b0;
    exec_en    = 1'b0;
    adl_load   = 1'b0;
    adl_n      = adl_q;
    adh_load   = 1'b0;
    adh_n      = adh_q;
    carry_load = 1'b0;
    carry_n    = carry_q;
    case (state_q)
      ST_FETCH: begin
        sync    = 1'b1;
        addr    = pc_q;
        ir_load = 1'b1;
        pc_inc  = 1'b1;
        state_n = ST_OPER;
      end
      ST_OPER: begin
        addr = pc_q;
        case (dec.mode)
          M_IMM: begin exec_en = 1'b1; pc_inc = 1'b1; state_n = ST_FETCH; end
          M_IMP: begin exec_en = 1'b1; illegal = !dec.legal; state_n = ST_FETCH; end
          M_ZP, M_ZPX: begin
            adl_load = 1'b1;
            adl_n    = d_in;
            adh_load = 1'b1;
            adh_n    = '0;
            pc_inc   = 1'b1;
            state_n  = (dec.mode == M_ZP) ? ST_EXEC : ST_ZPX;
          end
          default: begin
            adl_load = 1'b1;
            adl_n    = d_in;
            pc_inc   = 1'b1;
            state_n  = ST_ABSH;
          end
        endcase
      end
      ST_ZPX: begin
        adl_load = 1'b1;
        adl_n    = adl_q + x_q;
        state_n  = ST_EXEC;
      end
      ST_ABSH: begin
        addr     = pc_q;
        adh_load = 1'b1;
        adh_n    = d_in;
        pc_inc   = 1'b1;
        state_n  = ST_EXEC;
        if (dec.mode == M_ABX || dec.mode == M_ABY) begin
          adl_load   = 1'b1;
          adl_n      = idx_sum[MSB:0];
          carry_load = 1'b1;
          carry_n    = idx_sum[DATA_W];
          if (idx_sum[DATA_W] || dec.op == OP_STA) state_n = ST_FIX;
        end
      end
      ST_FIX: begin
        adh_load = 1'b1;
        adh_n    = adh_q + {{(DATA_W-1){1'b0}}, carry_q};
        state_n  = ST_EXEC;
      end
      ST_EXEC: begin
        if (dec.op == OP_STA) write = 1'b1;
        else exec_en = 1'b1;
        state_n = ST_FETCH;
      end
      default: state_n = ST_FETCH;
    endcase
  end

  // Only read cycles stall; a pending write always retires.
  assign advance = ready | write;
  assign d_out   = write ? a_q : '0;
  assign status  = {n_q, v_q, 1'b1, 1'b0, d_flag, 1'b0, z_q, c_q};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      a_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      ir_q    <= '0;
      adl_q   <= '0;
      adh_q   <= '0;
      carry_q <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
`ifdef DECIMAL_MODE_EN
      d_q     <= 1'b0;
`endif
    end else if (advance) begin
      state_q <= state_n;
      if (pc_inc)     pc_q    <= pc_q + 1'b1;
      if (ir_load)    ir_q    <= d_in;
      if (adl_load)   adl_q   <= adl_n;
      if (adh_load)   adh_q   <= adh_n;
      if (carry_load) carry_q <= carry_n;
      if (exec_en) begin
        a_q <= a_n;
        x_q <= x_n;
        y_q <= y_n;
        n_q <= n_n;
        v_q <= v_n;
        z_q <= z_n;
        c_q <= c_n;
`ifdef DECIMAL_MODE_EN
        d_q <= d_n;
`endif
      end
    end
  end

endmodule

// File: tb/tb_acc_core.sv
// Directed-program bench for acc_core: runs a small program from a byte memory and
// checks bus activity, cycle counts, registers and flags against hand-computed values.
module tb_acc_core;

  logic        clk, reset, ready;
  logic [7:0]  d_in, d_out, status;
  logic [15:0] addr;
  logic        write, sync, illegal;

  logic [7:0]  mem [0:65535];
  int          n_cmp = 0;
  int          n_err = 0;
  int          wr_cnt = 0;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;

  logic [7:0] prog [$] = '{
    8'hA9, 8'h7F,         // 0200 LDA #7F
    8'h69, 8'h01,         // 0202 ADC #01
    8'hA2, 8'hFF,         // 0204 LDX #FF
    8'hA9, 8'h55,         // 0206 LDA #55
    8'h9D, 8'hF0, 8'h12,  // 0208 STA 12F0,X
    8'hA0, 8'h01,         // 020B LDY #01
    8'hB9, 8'hFE, 8'h20,  // 020D LDA 20FE,Y
    8'hA2, 8'h10,         // 0210 LDX #10
    8'hB5, 8'hF8,         // 0212 LDA F8,X
    8'h38,                // 0214 SEC
    8'hA9, 8'h05,         // 0215 LDA #05
    8'hC9, 8'h05,         // 0217 CMP #05
    8'hE9, 8'h06,         // 0219 SBC #06
    8'h02,                // 021B illegal
    8'hAD, 8'h34, 8'h12,  // 021C LDA 1234
    8'h85, 8'h40,         // 021F STA 40
    8'hE8,                // 0221 INX
    8'hC8,                // 0222 INY
    8'h18,                // 0223 CLC
    8'hF8,                // 0224 SED
    8'h18,                // 0225 CLC
    8'hA9, 8'h19,         // 0226 LDA #19
    8'h69, 8'h28,         // 0228 ADC #28
    8'h69, 8'h53,         // 022A ADC #53
    8'h8D, 8'h00, 8'h30   // 022C STA 3000
  };

  acc_core #(.DATA_W(8), .ADDR_W(16), .RESET_PC(16'h0200)) dut (
    .clk     (clk),
    .reset   (reset),
    .ready   (ready),
    .d_in    (d_in),
    .d_out   (d_out),
    .addr    (addr),
    .write   (write),
    .sync    (sync),
    .illegal (illegal),
    .status  (status)
  );

  assign d_in = mem[addr];

  always @(posedge clk) begin
    if (write) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= addr;
      wr_data <= d_out;
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_to_fetch(input string tag, input int exp_cycles, input logic [15:0] exp_pc);
    int n;
    tick();
    n = 1;
    while (sync !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_cycles"}, n, exp_cycles);
    check({tag, "_pc"}, addr, exp_pc);
  endtask

  initial begin
    reset = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < prog.size(); i++) mem[16'h0200 + i] = prog[i];
    mem[16'h20FE] = 8'h22;
    mem[16'h20FF] = 8'h3C;
    mem[16'h21FF] = 8'h11;
    mem[16'h0008] = 8'h9A;
    mem[16'h0108] = 8'h77;
    mem[16'h1234] = 8'hC3;

    tick();
    tick();
    check("rst_sync", sync, 1'b1);
    check("rst_addr", addr, 16'h0200);
    check("rst_write", write, 1'b0);
    check("rst_status", status, 8'h20);
    check("rst_illegal", illegal, 1'b0);
    reset = 1'b1;

    run_to_fetch("lda7f", 2, 16'h0202);
    check("lda7f_a", dut.a_q, 8'h7F);
    run_to_fetch("adc01", 2, 16'h0204);
    check("adc01_a", dut.a_q, 8'h80);
    check("adc01_p", status, 8'hE0);
    run_to_fetch("ldxff", 2, 16'h0206);
    check("ldxff_x", dut.x_q, 8'hFF);
    run_to_fetch("lda55", 2, 16'h0208);
    check("lda55_p", status, 8'h60);

    tick();
    tick();
    tick();
    check("stax_t3_addr", addr, 16'h12EF);
    check("stax_t3_write", write, 1'b0);
    tick();
    check("stax_t4_addr", addr, 16'h13EF);
    check("stax_t4_write", write, 1'b1);
    check("stax_t4_dout", d_out, 8'h55);
    tick();
    check("stax_next_sync", sync, 1'b1);
    check("stax_next_pc", addr, 16'h020B);
    check("stax_mem_addr", wr_addr, 16'h13EF);
    check("stax_mem_data", wr_data, 8'h55);

    run_to_fetch("ldy01", 2, 16'h020D);
    check("ldy01_y", dut.y_q, 8'h01);
    run_to_fetch("ldaaby", 4, 16'h0210);
    check("ldaaby_a", dut.a_q, 8'h3C);
    run_to_fetch("ldx10", 2, 16'h0212);
    run_to_fetch("ldazpx", 4, 16'h0214);
    check("ldazpx_a", dut.a_q, 8'h9A);
    check("ldazpx_p", status, 8'hE0);
    run_to_fetch("sec", 2, 16'h0215);
    check("sec_p", status, 8'hE1);
    run_to_fetch("lda05", 2, 16'h0217);
    run_to_fetch("cmp05", 2, 16'h0219);
    check("cmp05_p", status, 8'h63);
    check("cmp05_a", dut.a_q, 8'h05);
    run_to_fetch("sbc06", 2, 16'h021B);
    check("sbc06_a", dut.a_q, 8'hFF);
    check("sbc06_p", status, 8'hA0);

    tick();
    check("ill_t1_pulse", illegal, 1'b1);
    check("ill_t1_addr", addr, 16'h021C);
    tick();
    check("ill_next_sync", sync, 1'b1);
    check("ill_next_pc", addr, 16'h021C);
    check("ill_cleared", illegal, 1'b0);
    check("ill_p", status, 8'hA0);
    check("ill_a", dut.a_q, 8'hFF);

    tick();
    tick();
    check("stall_t2_addr", addr, 16'h021E);
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_addr", addr, 16'h021E);
      check("stall_pc", dut.pc_q, 16'h021E);
      check("stall_sync", sync, 1'b0);
    end
    ready = 1'b1;
    tick();
    check("stall_t3_addr", addr, 16'h1234);
    tick();
    check("stall_next_sync", sync, 1'b1);
    check("stall_next_pc", addr, 16'h021F);
    check("ldaabs_a", dut.a_q, 8'hC3);
    check("ldaabs_p", status, 8'hA0);

    run_to_fetch("stazp", 3, 16'h0221);
    check("stazp_mem_addr", wr_addr, 16'h0040);
    check("stazp_mem_data", wr_data, 8'hC3);
    run_to_fetch("inx", 2, 16'h0222);
    check("inx_x", dut.x_q, 8'h11);
    run_to_fetch("iny", 2, 16'h0223);
    check("iny_y", dut.y_q, 8'h02);
    run_to_fetch("clc", 2, 16'h0224);
    check("clc_p", status, 8'h20);

    run_to_fetch("sed", 2, 16'h0225);
    run_to_fetch("clc2", 2, 16'h0226);
    run_to_fetch("lda19", 2, 16'h0228);
    run_to_fetch("adc28", 2, 16'h022A);
`ifdef DECIMAL_MODE_EN
    check("adc28_a", dut.a_q, 8'h47);
    check("adc28_p", status, 8'h28);
`else
    check("adc28_a", dut.a_q, 8'h41);
    check("adc28_p", status, 8'h20);
`endif
    run_to_fetch("adc53", 2, 16'h022C);
`ifdef DECIMAL_MODE_EN
    check("adc53_a", dut.a_q, 8'h00);
    check("adc53_p", status, 8'hE9);
`else
    check("adc53_a", dut.a_q, 8'h94);
    check("adc53_p", status, 8'hE0);
`endif

    tick();
    tick();
    tick();
    check("sta_abort_write_pre", write, 1'b1);
    check("sta_abort_addr_pre", addr, 16'h3000);
    reset = 1'b0;
    #1;
    check("abort_write", write, 1'b0);
    check("abort_dout", d_out, 8'h00);
    check("abort_addr", addr, 16'h0200);
    check("abort_sync", sync, 1'b1);
    check("abort_status", status, 8'h20);
    check("abort_a", dut.a_q, 8'h00);
    check("abort_x", dut.x_q, 8'h00);
    check("abort_y", dut.y_q, 8'h00);
    tick();
    tick();
    check("abort_no_write", wr_cnt, 2);
    reset = 1'b1;
    run_to_fetch("restart", 2, 16'h0202);
    check("restart_a", dut.a_q, 8'h7F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
